// File: rtl/mem_issue_queue_pkg.sv
// Shared micro-op types and default queue depth for the memory issue path.
// Pure type/constant package; no logic, latency or backpressure of its own.
package mem_issue_queue_pkg;

    localparam int MEM_IQ_DEPTH = 8;

    typedef enum logic [2:0] {
        FU_NONE   = 3'd0,
        FU_ALU    = 3'd1,
        FU_BRANCH = 3'd2,
        FU_MUL    = 3'd3,
        FU_MEM    = 3'd4
    } fu_code_t;

    typedef enum logic [1:0] {
        MEM_LD = 2'd0,
        MEM_ST = 2'd1
    } mem_type_t;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic      valid;
        fu_code_t  fu_code;
        mem_type_t mem_type;
        mem_size_t mem_size;
        logic [4:0]  rd;
        logic [31:0] pc;
    } micro_op_t;

endpackage

// File: rtl/mem_iq_fifo.sv
// Generic circular FIFO; head_dat is combinational from storage, writes land one edge after push.
// No internal stall: push into full or pop from empty is ignored, caller gates with full/empty.
module mem_iq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[head];

    // Pointers are exactly log2(DEPTH) wide, so the increment wraps on its own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[tail] <= push_dat;
                tail      <= tail + 1'b1;
            end
            if (pop_ok) head <= head + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order FU_MEM issue queue: 2-cycle dispatch-to-issue (1 with MEM_IQ_BYPASS_EN), min issue interval 2.
// in_ready drops only on registered full; issue stalls on ex_busy, flush drops everything.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int DEPTH = MEM_IQ_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  micro_op_t        uop_in,
    input  logic [31:0]      in1_in,
    input  logic [31:0]      in2_in,
    output logic             in_ready,
    input  logic             flush,
    input  logic             ex_busy,
    output micro_op_t        uop_out,
    output logic [31:0]      in1_out,
    output logic [31:0]      in2_out,
    output logic [CNT_W-1:0] count
);

    localparam int ENTRY_W = $bits(micro_op_t) + 64;

    logic               full;
    logic               empty;
    logic               issued_last;
    logic               push_req;
    logic               pop;
    logic               bypass;
    logic [ENTRY_W-1:0] head_dat;
    micro_op_t          head_uop;
    logic [31:0]        head_in1;
    logic [31:0]        head_in2;

    assign in_ready = !full;
    assign push_req = uop_in.valid && (uop_in.fu_code == FU_MEM) && in_ready && !flush;
    assign pop      = !empty && !ex_busy && !issued_last && !flush;
    assign {head_uop, head_in1, head_in2} = head_dat;

`ifdef MEM_IQ_BYPASS_EN
    // Empty queue and idle pipe: skip the buffer and issue straight from dispatch.
    assign bypass = push_req && empty && !ex_busy && !issued_last;
`else
    assign bypass = 1'b0;
`endif

    mem_iq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_req && !bypass),
        .push_dat ({uop_in, in1_in, in2_in}),
        .pop      (pop),
        .clear    (flush),
        .head_dat (head_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // issued_last forces a bubble: the pipe raises ex_busy one cycle after accepting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            uop_out     <= '0;
            in1_out     <= '0;
            in2_out     <= '0;
            issued_last <= 1'b0;
        end else begin
            issued_last <= pop || bypass;
            if (pop) begin
                uop_out <= head_uop;
                in1_out <= head_in1;
                in2_out <= head_in2;
            end else if (bypass) begin
                uop_out <= uop_in;
                in1_out <= in1_in;
                in2_out <= in2_in;
            end else begin
                uop_out.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: ordering, spacing, full, busy, flush, filtering, async reset.
module tb_mem_issue_queue;
    import mem_issue_queue_pkg::*;

`ifdef MEM_IQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clock;
    logic        reset;
    micro_op_t   uop_in;
    logic [31:0] in1_in;
    logic [31:0] in2_in;
    logic        in_ready;
    logic        flush;
    logic        ex_busy;
    micro_op_t   uop_out;
    logic [31:0] in1_out;
    logic [31:0] in2_out;
    logic [3:0]  count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          mon_cyc[$];
    logic [31:0] mon_pc[$];
    logic [31:0] mon_in1[$];
    logic [31:0] mon_in2[$];

    mem_issue_queue dut (
        .clock    (clock),
        .reset    (reset),
        .uop_in   (uop_in),
        .in1_in   (in1_in),
        .in2_in   (in2_in),
        .in_ready (in_ready),
        .flush    (flush),
        .ex_busy  (ex_busy),
        .uop_out  (uop_out),
        .in1_out  (in1_out),
        .in2_out  (in2_out),
        .count    (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset && uop_out.valid) begin
            mon_cyc.push_back(cyc);
            mon_pc.push_back(uop_out.pc);
            mon_in1.push_back(in1_out);
            mon_in2.push_back(in2_out);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mon_clear();
        mon_cyc.delete();
        mon_pc.delete();
        mon_in1.delete();
        mon_in2.delete();
    endtask

    task automatic drive(input logic [31:0] pc, input fu_code_t fu,
                         input logic [31:0] a, input logic [31:0] b);
        uop_in          = '0;
        uop_in.valid    = 1'b1;
        uop_in.fu_code  = fu;
        uop_in.mem_type = MEM_LD;
        uop_in.mem_size = MEM_W;
        uop_in.rd       = 5'd3;
        uop_in.pc       = pc;
        in1_in          = a;
        in2_in          = b;
    endtask

    task automatic no_in();
        uop_in = '0;
        in1_in = '0;
        in2_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; ex_busy = 1'b0; no_in();
        #2;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (uop_out !== '0) begin bad++; $display("FAIL reset_uop_out: got %h expected 0", uop_out); end
        total++; if (in1_out !== 32'h0) begin bad++; $display("FAIL reset_in1: got %h expected 0", in1_out); end
        total++; if (in2_out !== 32'h0) begin bad++; $display("FAIL reset_in2: got %h expected 0", in2_out); end
        step(); step();
        reset = 1'b1;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_load();
        int c0;
        mon_clear();
        ex_busy = 1'b0;
        c0 = cyc;
        drive(32'h100, FU_MEM, 32'h1000, 32'h0);
        step(); no_in();
        repeat (5) step();
        total++;
        if (mon_pc.size() != 1) begin
            bad++; $display("FAIL single_issue_cnt: got %0d expected 1", mon_pc.size());
        end else begin
            total++; if (mon_cyc[0] != c0 + LAT) begin bad++; $display("FAIL single_latency: got %0d expected %0d", mon_cyc[0] - c0, LAT); end
            total++; if (mon_pc[0] !== 32'h100) begin bad++; $display("FAIL single_pc: got %h expected 100", mon_pc[0]); end
            total++; if (mon_in1[0] !== 32'h1000) begin bad++; $display("FAIL single_in1: got %h expected 1000", mon_in1[0]); end
        end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL single_count: got %0d expected 0", count); end
    endtask

    task automatic test_back_to_back();
        int c0;
        mon_clear();
        ex_busy = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            drive(32'h100 + 32'(4 * i), FU_MEM, 32'h2000 + 32'(i), 32'h0);
            step();
        end
        no_in();
        repeat (8) step();
        total++;
        if (mon_pc.size() != 3) begin
            bad++; $display("FAIL b2b_issue_cnt: got %0d expected 3", mon_pc.size());
        end else begin
            total++; if (mon_cyc[0] != c0 + LAT) begin bad++; $display("FAIL b2b_first_latency: got %0d expected %0d", mon_cyc[0] - c0, LAT); end
            for (int i = 0; i < 3; i++) begin
                total++; if (mon_pc[i] !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL b2b_pc%0d: got %h expected %h", i, mon_pc[i], 32'h100 + 32'(4 * i)); end
                if (i > 0) begin
                    total++; if (mon_cyc[i] - mon_cyc[i-1] != 2) begin bad++; $display("FAIL b2b_gap%0d: got %0d expected 2", i, mon_cyc[i] - mon_cyc[i-1]); end
                end
            end
        end
    endtask

    task automatic test_fill();
        mon_clear();
        ex_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h200 + 32'(4 * i), FU_MEM, 32'h3000 + 32'(i), 32'hABCD0000 + 32'(i));
            step();
        end
        no_in();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count: got %0d expected 8", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
        drive(32'h300, FU_MEM, 32'h0, 32'h0);
        step(); no_in();
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_ninth_dropped: got %0d expected 8", count); end
        ex_busy = 1'b0;
        repeat (20) step();
        total++;
        if (mon_pc.size() != 8) begin
            bad++; $display("FAIL fill_issue_cnt: got %0d expected 8", mon_pc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++; if (mon_pc[i] !== 32'h200 + 32'(4 * i)) begin bad++; $display("FAIL fill_pc%0d: got %h expected %h", i, mon_pc[i], 32'h200 + 32'(4 * i)); end
                total++; if (mon_in2[i] !== 32'hABCD0000 + 32'(i)) begin bad++; $display("FAIL fill_in2_%0d: got %h expected %h", i, mon_in2[i], 32'hABCD0000 + 32'(i)); end
            end
        end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL fill_drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_busy();
        logic found;
        ex_busy = 1'b0;
        drive(32'h400, FU_MEM, 32'h4000, 32'h0);
        step();
        found = uop_out.valid;
        drive(32'h404, FU_MEM, 32'h4004, 32'h0);
        for (int i = 0; i < 6 && !found; i++) begin
            step(); no_in();
            found = uop_out.valid;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL busy_first_issue: got no issue expected issue of 400");
        end else begin
            total++; if (uop_out.pc !== 32'h400) begin bad++; $display("FAIL busy_first_pc: got %h expected 400", uop_out.pc); end
            ex_busy = 1'b1;
            for (int i = 1; i <= 6; i++) begin
                step(); no_in();
                if (i < 6) begin
                    total++; if (uop_out.valid !== 1'b0) begin bad++; $display("FAIL busy_idle%0d: got valid %b expected 0", i, uop_out.valid); end
                    if (i == 5) ex_busy = 1'b0;
                end else begin
                    total++; if (uop_out.valid !== 1'b1) begin bad++; $display("FAIL busy_resume_valid: got %b expected 1", uop_out.valid); end
                    total++; if (uop_out.pc !== 32'h404) begin bad++; $display("FAIL busy_resume_pc: got %h expected 404", uop_out.pc); end
                    total++; if (in1_out !== 32'h4004) begin bad++; $display("FAIL busy_resume_in1: got %h expected 4004", in1_out); end
                end
            end
        end
        no_in();
        repeat (3) step();
    endtask

    task automatic test_flush();
        ex_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(32'h500 + 32'(4 * i), FU_MEM, 32'h5000, 32'h0);
            step();
        end
        no_in();
        total++; if (count !== 4'd4) begin bad++; $display("FAIL flush_pre_count: got %0d expected 4", count); end
        flush = 1'b1;
        drive(32'h5F0, FU_MEM, 32'h5F00, 32'h0);
        step();
        flush = 1'b0; no_in();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL flush_count: got %0d expected 0", count); end
        total++; if (uop_out.valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b expected 0", uop_out.valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        mon_clear();
        ex_busy = 1'b0;
        repeat (10) step();
        total++; if (mon_pc.size() != 0) begin bad++; $display("FAIL flush_no_issue: got %0d issues expected 0", mon_pc.size()); end
    endtask

    task automatic test_non_mem();
        mon_clear();
        ex_busy = 1'b0;
        drive(32'h600, FU_ALU, 32'h6000, 32'h0);
        step(); no_in();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL nonmem_count: got %0d expected 0", count); end
        repeat (5) step();
        total++; if (mon_pc.size() != 0) begin bad++; $display("FAIL nonmem_no_issue: got %0d issues expected 0", mon_pc.size()); end
    endtask

    task automatic test_async_reset();
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h700 + 32'(4 * i), FU_MEM, 32'h7000, 32'h0);
            step();
        end
        no_in();
        total++; if (count !== 4'd3) begin bad++; $display("FAIL arst_pre_count: got %0d expected 3", count); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL arst_count: got %0d expected 0", count); end
        total++; if (uop_out !== '0) begin bad++; $display("FAIL arst_uop_out: got %h expected 0", uop_out); end
        total++; if (in1_out !== 32'h0) begin bad++; $display("FAIL arst_in1: got %h expected 0", in1_out); end
        step();
        reset = 1'b1;
        ex_busy = 1'b0;
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL arst_post_count: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_back_to_back();
        test_fill();
        test_busy();
        test_flush();
        test_non_mem();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
